com_bus_arbiter_rr: RTL
=======================

// Module: com_bus_arbiter_rr
// PURPOSE
// Parametrised common-bus arbiter for the MESI multi-core cache system. It grants the shared
// Address_Com/Data_Bus_Com bus to one of NUM_PROC processor-side caches, NUM_SNOOP snoop-side
// controllers or the lower-level memory snoop port. Sits between per-core cache controllers
// and the bus/memory. Supersedes the fixed 8-proc/4-snoop request/grant wiring with
// round-robin fairness, a starvation guard and a hold-timeout watchdog.
// PARAMETERS
// NUM_PROC      8    processor request/grant channels (2..16)
// NUM_SNOOP     4    snoop request/grant channels (1..8)
// STARVE_LIMIT  4    consecutive non-proc grants tolerated while any proc request is pending
// MAX_HOLD      64   max cycles one grant may be held; 0 disables the watchdog
// PORTS
// clk                  in   1          bus clock, rising edge
// rst_n                in   1          asynchronous active-low reset
// Com_Bus_Req_proc     in   NUM_PROC   level request per processor cache, held until done
// Com_Bus_Req_snoop    in   NUM_SNOOP  level request per snoop controller
// Mem_snoop_req        in   1          lower-level memory request
// Com_Bus_Gnt_proc     out  NUM_PROC   one-hot registered grant
// Com_Bus_Gnt_snoop    out  NUM_SNOOP  one-hot registered grant
// Mem_snoop_gnt        out  1          registered memory grant
// Bus_busy             out  1          1 while any grant is asserted
// Timeout_err          out  1          one-cycle pulse when a grant is revoked by the watchdog
// BEHAVIOUR
// - One clock, clk; asynchronous active-low reset rst_n. All outputs are registered.
// - Reset: all grants 0, Bus_busy 0, Timeout_err 0, both RR pointers 0, starve_cnt 0,
//   hold_cnt 0, FSM in IDLE. Reset mid-grant drops the grant immediately (asynchronously).
// - At most one grant is asserted across all three grant outputs in any cycle.
// - FSM states: IDLE, GNT_MEM, GNT_SNOOP, GNT_PROC, RELEASE.
// - IDLE, arbitration order:
//   1. Mem_snoop_req -> GNT_MEM.
//   2. Else if starve_cnt==STARVE_LIMIT and any proc request -> GNT_PROC.
//   3. Else any snoop request -> GNT_SNOOP.
//   4. Else any proc request -> GNT_PROC.
//   5. Else stay in IDLE.
// - Grant latency: a request sampled in IDLE at edge N produces a grant visible after edge N+1.
// - Round-robin: search starts at the class pointer and wraps modulo the channel count. After a
//   grant to index i, the pointer becomes (i+1) mod N; index N-1 wraps to 0. Each pointer is
//   $clog2(N) bits.
// - starve_cnt, saturating at STARVE_LIMIT:
//   - +1 on each GNT_MEM/GNT_SNOOP entry while any proc request is pending;
//   - cleared on GNT_PROC entry;
//   - cleared when no proc request is pending.
// - GNT_*: the grant holds while the granted request stays 1. Request drop -> RELEASE.
//   Requests from other channels are ignored; there is no pre-emption.
// - hold_cnt counts grant cycles. If MAX_HOLD!=0 and hold_cnt reaches MAX_HOLD-1 with the
//   request still high:
//   - the grant is removed;
//   - Timeout_err pulses for 1 cycle;
//   - the FSM goes to RELEASE;
//   - the RR pointer still advances past the offender.
// - RELEASE: exactly one idle turnaround cycle with all grants 0, Bus_busy 0, then IDLE.
// - Simultaneous request drop and timeout in the same cycle: treat as a normal release,
//   no Timeout_err.
// - A request that deasserts before its grant arrives still gets a 1-cycle grant, then
//   RELEASE.
// TESTING
// - Reset: rst_n=0 with all requests high -> all grants 0, Bus_busy 0; release reset ->
//   Mem_snoop_gnt=1 two edges later.
// - Proc RR: proc reqs 0,3,7 held, each dropped after 2 grant cycles -> grant order 0,3,7,0;
//   1 RELEASE cycle between grants.
// - Class priority: Mem_snoop_req, snoop[2] and proc[1] all high in IDLE -> Mem_snoop_gnt
//   first, then Com_Bus_Gnt_snoop[2], then Com_Bus_Gnt_proc[1].
// - Starvation (STARVE_LIMIT=4): snoop[0..3] requesting continuously with proc[5] pending ->
//   proc[5] granted after exactly 4 snoop grants.
// - Watchdog (MAX_HOLD=8): proc[2] holds its request forever -> grant is high 8 cycles,
//   Timeout_err pulses once, next grant goes to proc[3] if it is requesting.
// - Wrap/reset mid-op: NUM_PROC=8, pointer at 7, reqs 7 and 0 -> grant 7, then 0.
//   Asserting rst_n=0 during grant -> grant drops with no clock edge.

Source files
------------

// File: rtl/com_bus_arbiter_rr_if.sv
// Request/grant bundle between the MESI cache controllers, the memory snoop port
// and the common-bus arbiter.
interface com_bus_arbiter_rr_if #(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4
);
  logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
  logic                 Mem_snoop_req;
  logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
  logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop;
  logic                 Mem_snoop_gnt;
  logic                 Bus_busy;
  logic                 Timeout_err;

  modport master (
    output Com_Bus_Req_proc,
    output Com_Bus_Req_snoop,
    output Mem_snoop_req,
    input  Com_Bus_Gnt_proc,
    input  Com_Bus_Gnt_snoop,
    input  Mem_snoop_gnt,
    input  Bus_busy,
    input  Timeout_err
  );

  modport slave (
    input  Com_Bus_Req_proc,
    input  Com_Bus_Req_snoop,
    input  Mem_snoop_req,
    output Com_Bus_Gnt_proc,
    output Com_Bus_Gnt_snoop,
    output Mem_snoop_gnt,
    output Bus_busy,
    output Timeout_err
  );
endinterface

// File: rtl/com_bus_arbiter_rr.sv
// Common-bus arbiter: memory > (starved proc) > snoop > proc, round-robin within each
// class, one turnaround cycle between grants and a hold-time watchdog.
module com_bus_arbiter_rr #(
  parameter int NUM_PROC     = 8,
  parameter int NUM_SNOOP    = 4,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_HOLD     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  com_bus_arbiter_rr_if.slave bus
);

  localparam int PPW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int SPW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
  localparam int CW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    GNT_MEM,
    GNT_SNOOP,
    GNT_PROC,
    RELEASE
  } state_e;

  state_e               state_q;
  logic [NUM_PROC-1:0]  req_proc_q;
  logic [NUM_SNOOP-1:0] req_snoop_q;
  logic                 req_mem_q;
  logic [NUM_PROC-1:0]  gnt_proc_q;
  logic [NUM_SNOOP-1:0] gnt_snoop_q;
  logic                 gnt_mem_q;
  logic                 busy_q;
  logic                 timeout_q;
  logic [PPW-1:0]       proc_ptr_q;
  logic [SPW-1:0]       snoop_ptr_q;
  logic [CW-1:0]        starve_q;
  logic [HW-1:0]        hold_q;

  logic                 proc_found_d;
  logic [PPW-1:0]       proc_pick_d;
  logic                 snoop_found_d;
  logic [SPW-1:0]       snoop_pick_d;
  logic                 held_d;
  logic                 wd_expire_d;
  logic                 proc_pend_d;
  logic                 starve_hit_d;
  logic                 take_proc_d;
  int                   pidx;
  int                   sidx;

  function automatic logic [CW-1:0] starve_inc(input logic [CW-1:0] v);
    return (v == CW'(STARVE_LIMIT)) ? v : v + CW'(1);
  endfunction

  function automatic logic [PPW-1:0] proc_ptr_next(input logic [PPW-1:0] idx);
    return (idx == PPW'(NUM_PROC - 1)) ? '0 : idx + PPW'(1);
  endfunction

  function automatic logic [SPW-1:0] snoop_ptr_next(input logic [SPW-1:0] idx);
    return (idx == SPW'(NUM_SNOOP - 1)) ? '0 : idx + SPW'(1);
  endfunction

  // Round-robin search over the registered requests, starting at each class pointer.
  always_comb begin
    proc_found_d = 1'b0;
    proc_pick_d  = '0;
    pidx         = 0;
    for (int k = 0; k < NUM_PROC; k++) begin
      pidx = (int'(proc_ptr_q) + k) % NUM_PROC;
      if (!proc_found_d && req_proc_q[PPW'(pidx)]) begin
        proc_found_d = 1'b1;
        proc_pick_d  = PPW'(pidx);
      end
    end
  end

  always_comb begin
    snoop_found_d = 1'b0;
    snoop_pick_d  = '0;
    sidx          = 0;
    for (int k = 0; k < NUM_SNOOP; k++) begin
      sidx = (int'(snoop_ptr_q) + k) % NUM_SNOOP;
      if (!snoop_found_d && req_snoop_q[SPW'(sidx)]) begin
        snoop_found_d = 1'b1;
        snoop_pick_d  = SPW'(sidx);
      end
    end
  end

  // The holder is judged on its live request so a drop releases the bus on the next edge.
  always_comb begin
    case (state_q)
      GNT_MEM:   held_d = bus.Mem_snoop_req;
      GNT_SNOOP: held_d = |(bus.Com_Bus_Req_snoop & gnt_snoop_q);
      GNT_PROC:  held_d = |(bus.Com_Bus_Req_proc & gnt_proc_q);
      default:   held_d = 1'b0;
    endcase
  end

  assign wd_expire_d  = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1));
  assign proc_pend_d  = |req_proc_q;
  assign starve_hit_d = (starve_q == CW'(STARVE_LIMIT));
  assign take_proc_d  = proc_found_d && (starve_hit_d || !snoop_found_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_proc_q  <= '0;
      req_snoop_q <= '0;
      req_mem_q   <= 1'b0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      gnt_mem_q   <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      proc_ptr_q  <= '0;
      snoop_ptr_q <= '0;
      starve_q    <= '0;
      hold_q      <= '0;
    end else begin
      req_proc_q  <= bus.Com_Bus_Req_proc;
      req_snoop_q <= bus.Com_Bus_Req_snoop;
      req_mem_q   <= bus.Mem_snoop_req;
      timeout_q   <= 1'b0;
      if (!proc_pend_d) begin
        starve_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (req_mem_q) begin
            state_q   <= GNT_MEM;
            gnt_mem_q <= 1'b1;
            busy_q    <= 1'b1;
            hold_q    <= '0;
            if (proc_pend_d) begin
              starve_q <= starve_inc(starve_q);
            end
          end else if (take_proc_d) begin
            state_q    <= GNT_PROC;
            gnt_proc_q <= NUM_PROC'(1) << proc_pick_d;
            proc_ptr_q <= proc_ptr_next(proc_pick_d);
            busy_q     <= 1'b1;
            hold_q     <= '0;
            starve_q   <= '0;
          end else if (snoop_found_d) begin
            state_q     <= GNT_SNOOP;
            gnt_snoop_q <= NUM_SNOOP'(1) << snoop_pick_d;
            snoop_ptr_q <= snoop_ptr_next(snoop_pick_d);
            busy_q      <= 1'b1;
            hold_q      <= '0;
            if (proc_pend_d) begin
              starve_q <= starve_inc(starve_q);
            end
          end
        end
        GNT_MEM, GNT_SNOOP, GNT_PROC: begin
          // A drop coinciding with expiry counts as an ordinary release.
          if (!held_d || wd_expire_d) begin
            state_q     <= RELEASE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            gnt_mem_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= held_d;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        RELEASE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          gnt_proc_q  <= '0;
          gnt_snoop_q <= '0;
          gnt_mem_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
  assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
  assign bus.Mem_snoop_gnt     = gnt_mem_q;
  assign bus.Bus_busy          = busy_q;
  assign bus.Timeout_err       = timeout_q;

endmodule
